mat_vec_engine: RTL and testbench



---
 rtl/mat_vec_engine.sv | 192 +++++++++++++++++++
 tb/tb_mat_vec_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_engine.sv
// rtl/mat_vec_engine.sv - matrix register file with column ops and matrix-vector multiply-accumulate
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   cmd       command word {op, mat_a, col_a, mat_b, col_b, mat_c, col_c, flags}, sampled on accept
//   stb       command request, held by the master until ack
//   data_in   write vector, element i at [i*WIDTH +: WIDTH]
//   data_out  read vector, non-zero only in the ack cycle of a read op
//   ack       one-cycle completion pulse
//   err       qualifies ack: command rejected, nothing changed
//   busy      high from the cycle after accept through the ack cycle
module mat_vec_engine #(
   parameter int MAT_COUNT = 4,
   parameter int DIM       = 4,
   parameter int WIDTH     = 16,
   parameter int FRAC      = 12,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          cmd,
   input  logic                 stb,
   input  logic [DIM*WIDTH-1:0] data_in,
   output logic [DIM*WIDTH-1:0] data_out,
   output logic                 ack,
   output logic                 err,
   output logic                 busy
);
   localparam int MW = $clog2(MAT_COUNT);
   localparam int DW = $clog2(DIM);
   localparam int AW = 2*WIDTH + $clog2(DIM) + 1;

   localparam logic [3:0] OP_RD_COL = 4'd0;
   localparam logic [3:0] OP_WR_COL = 4'd1;
   localparam logic [3:0] OP_MUL    = 4'd2;
   localparam logic [3:0] OP_ADD    = 4'd3;
   localparam logic [3:0] OP_RD_ROW = 4'd4;
   localparam logic [3:0] OP_CLEAR  = 4'd5;

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_MAC, S_WB} state_t;
   typedef logic signed [AW-1:0] acc_t;

   localparam acc_t MAXV = acc_t'({1'b0, {(WIDTH-1){1'b1}}});
   localparam acc_t MINV = ~MAXV;

   state_t                                            state_q, state_d;
   logic [DW-1:0]                                     k_q, k_d;
   logic [MAT_COUNT-1:0][DIM-1:0][DIM-1:0][WIDTH-1:0] mem_q;
   logic [DIM-1:0][AW-1:0]                            acc_q, acc_d;
   logic [DIM-1:0][WIDTH-1:0]                         bsnap_q;
   logic [MW-1:0]                                     ma_q, mc_q;
   logic [DW-1:0]                                     cc_q;
   logic                                              accf_q, rej_q, rd_q;
   logic [DIM*WIDTH-1:0]                              rdata_q;

   logic [3:0]                op;
   logic [MW-1:0]             ma, mb, mc;
   logic [DW-1:0]             ca, cb, cc;
   logic                      valid, accept;
   logic [DIM-1:0][WIDTH-1:0] col_a, col_b, row_b, add_res, wb_res, wr_vec;
   logic                      unused_flags;

   assign op = cmd[31:28];
   assign ma = cmd[24 +: MW];
   assign ca = cmd[20 +: DW];
   assign mb = cmd[16 +: MW];
   assign cb = cmd[12 +: DW];
   assign mc = cmd[8 +: MW];
   assign cc = cmd[4 +: DW];
   assign wr_vec = data_in;
   assign unused_flags = ^cmd[3:1];
   assign accept = (state_q == S_IDLE) && stb;

   function automatic logic mat_ok(input logic [3:0] f);
      return 32'(f) < 32'(MAT_COUNT);
   endfunction

   function automatic logic col_ok(input logic [3:0] f);
      return 32'(f) < 32'(DIM);
   endfunction

   // Clamp or wrap a wide signed value into one element.
   function automatic logic [WIDTH-1:0] fit(input acc_t v);
      logic [WIDTH-1:0] r;
      r = v[WIDTH-1:0];
      if (SATURATE) begin
         if (v > MAXV)      r = MAXV[WIDTH-1:0];
         else if (v < MINV) r = MINV[WIDTH-1:0];
      end
      return r;
   endfunction

   // Full 4-bit fields are checked so indices beyond the array never alias.
   always_comb begin
      valid = 1'b0;
      case (op)
         OP_RD_COL, OP_RD_ROW: valid = mat_ok(cmd[19:16]) && col_ok(cmd[15:12]);
         OP_WR_COL: valid = mat_ok(cmd[11:8]) && col_ok(cmd[7:4]);
         OP_MUL:    valid = mat_ok(cmd[27:24]) && mat_ok(cmd[19:16]) && col_ok(cmd[15:12])
                            && mat_ok(cmd[11:8]) && col_ok(cmd[7:4]);
         OP_ADD:    valid = mat_ok(cmd[27:24]) && col_ok(cmd[23:20]) && mat_ok(cmd[19:16])
                            && col_ok(cmd[15:12]) && mat_ok(cmd[11:8]) && col_ok(cmd[7:4]);
         OP_CLEAR:  valid = mat_ok(cmd[11:8]);
         default:   valid = 1'b0;
      endcase
   end

   always_comb begin
      acc_t base;
      acc_t prod;
      base = '0;
      prod = '0;
      for (int i = 0; i < DIM; i++) begin
         col_a[i]   = mem_q[ma][DW'(i)][ca];
         col_b[i]   = mem_q[mb][DW'(i)][cb];
         row_b[i]   = mem_q[mb][cb][DW'(i)];
         add_res[i] = fit(acc_t'($signed(col_a[i])) + acc_t'($signed(col_b[i])));
         // MAC_0 seeds the accumulator; C is re-aligned to the product's binary point.
         base = accf_q ? (acc_t'($signed(mem_q[mc_q][DW'(i)][cc_q])) <<< FRAC) : '0;
         prod = acc_t'($signed(mem_q[ma_q][DW'(i)][k_q])) * acc_t'($signed(bsnap_q[k_q]));
         acc_d[i]  = ((k_q == '0) ? base : $signed(acc_q[i])) + prod;
         wb_res[i] = fit($signed(acc_q[i]) >>> FRAC);
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            k_d = '0;
            if (stb) state_d = (valid && op == OP_MUL) ? S_MAC : S_RESP;
         end
         S_RESP: state_d = S_IDLE;
         S_MAC: begin
            if (k_q == DW'(DIM-1)) state_d = S_WB;
            else                   k_d = k_q + 1'b1;
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign ack      = (state_q == S_RESP) || (state_q == S_WB);
   assign err      = (state_q == S_RESP) && rej_q;
   assign busy     = (state_q != S_IDLE);
   assign data_out = (state_q == S_RESP && rd_q) ? rdata_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         mem_q   <= '0;
         acc_q   <= '0;
         bsnap_q <= '0;
         ma_q    <= '0;
         mc_q    <= '0;
         cc_q    <= '0;
         accf_q  <= 1'b0;
         rej_q   <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (state_q == S_MAC) acc_q <= acc_d;
         if (accept) begin
            rej_q   <= !valid;
            rd_q    <= valid && (op == OP_RD_COL || op == OP_RD_ROW);
            rdata_q <= (op == OP_RD_ROW) ? row_b : col_b;
            // B is captured now so a MUL writing into A or B reads pre-op values.
            bsnap_q <= col_b;
            ma_q    <= ma;
            mc_q    <= mc;
            cc_q    <= cc;
            accf_q  <= cmd[0];
            if (valid) begin
               case (op)
                  OP_WR_COL: for (int i = 0; i < DIM; i++) mem_q[mc][DW'(i)][cc] <= wr_vec[i];
                  OP_ADD:    for (int i = 0; i < DIM; i++) mem_q[mc][DW'(i)][cc] <= add_res[i];
                  OP_CLEAR:  mem_q[mc] <= '0;
                  default: ;
               endcase
            end
         end
         if (state_q == S_WB) begin
            for (int i = 0; i < DIM; i++) mem_q[mc_q][DW'(i)][cc_q] <= wb_res[i];
         end
      end
   end
endmodule

// File: tb/tb_mat_vec_engine.sv
// tb/tb_mat_vec_engine.sv - scoreboard bench for mat_vec_engine (4x4 saturating and 8x8 wrapping instances)
module tb_mat_vec_engine;
   localparam int W  = 16;
   localparam int D0 = 4;
   localparam int D1 = 8;

   logic            clk   = 1'b0;
   logic            rst   = 1'b1;
   logic [31:0]     cmd_r = '0;
   logic            stb_r = 1'b0;
   logic            sel   = 1'b0;
   logic [D1*W-1:0] din_r = '0;

   logic [D0*W-1:0] dout0;
   logic [D1*W-1:0] dout1, dout;
   logic            ack0, err0, busy0, ack1, err1, busy1, ack, err, busy;

   always #5 clk = ~clk;

   mat_vec_engine #(.MAT_COUNT(4), .DIM(D0), .WIDTH(W), .FRAC(12), .SATURATE(1'b1)) u0 (
      .clk(clk), .rst(rst), .cmd(cmd_r), .stb(stb_r & ~sel), .data_in(din_r[D0*W-1:0]),
      .data_out(dout0), .ack(ack0), .err(err0), .busy(busy0));

   mat_vec_engine #(.MAT_COUNT(8), .DIM(D1), .WIDTH(W), .FRAC(12), .SATURATE(1'b0)) u1 (
      .clk(clk), .rst(rst), .cmd(cmd_r), .stb(stb_r & sel), .data_in(din_r),
      .data_out(dout1), .ack(ack1), .err(err1), .busy(busy1));

   assign ack  = sel ? ack1 : ack0;
   assign err  = sel ? err1 : err0;
   assign busy = sel ? busy1 : busy0;
   assign dout = sel ? dout1 : {{((D1-D0)*W){1'b0}}, dout0};

   typedef struct packed {
      logic            err;
      logic [D1*W-1:0] vec;
      logic [7:0]      lat;
      logic [15:0]     id;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   int   nid     = 0;

   task automatic check(input string tag, input logic [D1*W-1:0] got, input logic [D1*W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Accept cycle bookkeeping: the edge that sees stb with the DUT idle is the accept.
   always @(posedge clk) begin
      if (!rst && stb_r && !busy) acc_cyc <= cyc;
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 1'b1, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("err#%0d", mon_e.id), err, mon_e.err);
            check($sformatf("data#%0d", mon_e.id), dout, mon_e.vec);
            check($sformatf("lat#%0d", mon_e.id), cyc - acc_cyc, mon_e.lat);
         end
      end else if (dout != '0) begin
         check("dout_idle", dout, '0);
      end
   end

   function automatic logic [31:0] mk(input int op, ma, ca, mb, cb, mc, cc, fl);
      return {4'(op), 4'(ma), 4'(ca), 4'(mb), 4'(cb), 4'(mc), 4'(cc), 4'(fl)};
   endfunction

   function automatic logic [D1*W-1:0] v4(input logic [15:0] e0, e1, e2, e3);
      return {64'd0, e3, e2, e1, e0};
   endfunction

   function automatic logic [D1*W-1:0] v8(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
      return {e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   function automatic logic [D1*W-1:0] unit(input int k, input logic [15:0] val);
      logic [D1*W-1:0] r;
      r = '0;
      r[k*W +: W] = val;
      return r;
   endfunction

   task automatic expect_ack(input logic e_err, input logic [D1*W-1:0] vec, input int lat);
      exp_t e;
      e.err = e_err;
      e.vec = vec;
      e.lat = 8'(lat);
      e.id  = 16'(nid);
      nid++;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (exp_q.size() != 0) begin
         check("ack_timeout", 128'(exp_q.size()), '0);
         exp_q.delete();
      end
      stb_r = 1'b0;
   endtask

   task automatic send(input logic [31:0] c, input logic [D1*W-1:0] d, input logic e_err,
                       input logic [D1*W-1:0] vec, input int lat);
      @(negedge clk);
      cmd_r = c;
      din_r = d;
      stb_r = 1'b1;
      expect_ack(e_err, vec, lat);
      drain();
   endtask

   task automatic wr(input int m, input int c, input logic [D1*W-1:0] v);
      send(mk(1, 0, 0, 0, 0, m, c, 0), v, 1'b0, '0, 1);
   endtask

   task automatic rd(input int m, input int c, input logic [D1*W-1:0] v);
      send(mk(0, 0, 0, m, c, 0, 0, 0), '0, 1'b0, v, 1);
   endtask

   task automatic rejected(input logic [31:0] c);
      send(c, '0, 1'b1, '0, 1);
   endtask

   // Start a MUL, assert rst while it sits in MAC_2, expect no ack and an idle engine.
   task automatic rst_mid_mul(input logic [31:0] c);
      @(negedge clk);
      cmd_r = c;
      stb_r = 1'b1;
      @(negedge clk);
      stb_r = 1'b0;
      check("busy_mac0", busy, 1'b1);
      repeat (2) @(negedge clk);
      check("busy_mac2", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("busy_after_rst", busy, 1'b0);
      check("ack_after_rst", ack, 1'b0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_ack", ack, 1'b0);
         check("rst_err", err, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_dout", dout, '0);
      end
      sel = 1'b0;
      rd(0, 0, '0);

      // identity multiply
      for (int k = 0; k < D0; k++) wr(0, k, unit(k, 16'h1000));
      wr(1, 0, v4(16'h1000, 16'h2000, 16'hF000, 16'h0800));
      send(mk(2, 0, 0, 1, 0, 2, 1, 0), '0, 1'b0, '0, D0 + 1);
      rd(2, 1, v4(16'h1000, 16'h2000, 16'hF000, 16'h0800));

      // 2.0 scaling with saturation
      for (int k = 0; k < D0; k++) wr(0, k, unit(k, 16'h2000));
      wr(1, 1, v4(16'h6000, 16'h1000, 16'hA000, 16'h0000));
      send(mk(2, 0, 0, 1, 1, 2, 2, 0), '0, 1'b0, '0, D0 + 1);
      rd(2, 2, v4(16'h7FFF, 16'h2000, 16'h8000, 16'h0000));

      // accumulate with B aliased to C
      for (int k = 0; k < D0; k++) wr(0, k, unit(k, 16'h1000));
      wr(3, 0, v4(16'h1000, 16'h1800, 16'hF000, 16'h0400));
      send(mk(2, 0, 0, 3, 0, 3, 0, 1), '0, 1'b0, '0, D0 + 1);
      rd(3, 0, v4(16'h2000, 16'h3000, 16'hE000, 16'h0800));

      // transpose view, add, clear
      wr(2, 0, v4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
      wr(2, 3, v4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
      send(mk(4, 0, 0, 2, 1, 0, 0, 0), '0, 1'b0, v4(16'h0022, 16'h2000, 16'h2000, 16'h0002), 1);
      wr(1, 2, v4(16'h7000, 16'h1000, 16'h9000, 16'hFFFF));
      wr(1, 3, v4(16'h2000, 16'h0100, 16'h9000, 16'h0001));
      send(mk(3, 1, 2, 1, 3, 3, 1, 0), '0, 1'b0, '0, 1);
      rd(3, 1, v4(16'h7FFF, 16'h1100, 16'h8000, 16'h0000));
      send(mk(5, 0, 0, 0, 0, 2, 0, 0), '0, 1'b0, '0, 1);
      rd(2, 1, '0);
      send(mk(4, 0, 0, 2, 0, 0, 0, 0), '0, 1'b0, '0, 1);

      // rejected commands leave state alone
      rejected(mk(7, 0, 0, 0, 0, 3, 1, 0));
      rd(3, 1, v4(16'h7FFF, 16'h1100, 16'h8000, 16'h0000));
      rejected(mk(1, 0, 0, 0, 0, 5, 0, 0));
      rejected(mk(1, 0, 0, 0, 0, 3, 4, 0));
      rejected(mk(4, 0, 0, 1, 4, 0, 0, 0));
      rejected(mk(2, 4, 0, 1, 0, 3, 1, 0));
      rd(3, 1, v4(16'h7FFF, 16'h1100, 16'h8000, 16'h0000));

      // stb held through a MUL: the second command waits for the ack and sees the writeback
      @(negedge clk);
      cmd_r = mk(2, 0, 0, 1, 0, 2, 1, 0);
      stb_r = 1'b1;
      expect_ack(1'b0, '0, D0 + 1);
      @(negedge clk);
      check("busy_mul", busy, 1'b1);
      cmd_r = mk(0, 0, 0, 2, 1, 0, 0, 0);
      expect_ack(1'b0, v4(16'h1000, 16'h2000, 16'hF000, 16'h0800), 1);
      drain();

      rst_mid_mul(mk(2, 0, 0, 1, 0, 3, 1, 0));
      rd(3, 1, '0);
      rd(1, 0, '0);
      rd(0, 0, '0);

      // 8x8 wrapping instance
      sel = 1'b1;
      for (int k = 0; k < D1; k++) wr(0, k, unit(k, 16'h2000));
      wr(1, 0, v8(16'h6000, 16'h1000, 16'hA000, 0, 0, 0, 0, 16'h0010));
      send(mk(2, 0, 0, 1, 0, 2, 0, 0), '0, 1'b0, '0, D1 + 1);
      rd(2, 0, v8(16'hC000, 16'h2000, 16'h4000, 0, 0, 0, 0, 16'h0020));
      wr(7, 7, v8(1, 2, 3, 4, 5, 6, 7, 8));
      rd(7, 7, v8(1, 2, 3, 4, 5, 6, 7, 8));
      rejected(mk(1, 0, 0, 0, 0, 8, 0, 0));
      rst_mid_mul(mk(2, 0, 0, 1, 0, 2, 0, 1));
      rd(2, 0, '0);
      rd(7, 7, '0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
